sys_cmd_ctrl: RTL and testbench

Command controller for the UART-controlled system. It decodes the byte stream from the UART receiver (after synchronisation into the reference clock domain) and sequences the register file, the ALU and the TX FIFO to execute the four frame commands. The commands are register write 0xAA, register read 0xBB, ALU with operands 0xCC and ALU without operands 0xDD. Results go to the TX FIFO as bytes, least significant byte first for ALU results. The block sits in the reference-clock domain, between the RX data synchroniser and the register file, ALU and TX FIFO write port.

---
 rtl/sys_cmd_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_ctrl.sv
// Command controller: decodes UART frame bytes and sequences the register file, the ALU and the TX FIFO.
// Latency: register and ALU strobes fire one cycle after the sampling edge; ALU result to FIFO takes 2 pushes (LS, MS).
// Backpressure: TX states hold while fifo_full is high, with fifo_wr_data stable; RX bytes arriving in wait/TX states are dropped.
//
// Ports:
//   clk, rst                   reference clock, async active-high reset
//   rx_p_data, rx_d_valid      synchronised RX byte stream
//   rf_*                       register-file address, write strobe/data, read strobe, read data/valid
//   alu_*                      ALU start strobe, function code, result/valid; gate_en is the ALU clock-gate enable
//   fifo_*                     TX FIFO write data, push and full
//   cmd_error                  one-cycle pulse for an unknown command byte in IDLE
module sys_cmd_ctrl #(
  parameter int data_width     = 8,
  parameter int addre_width    = 4,
  parameter int alu_func_width = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [data_width-1:0]     rx_p_data,
  input  logic                      rx_d_valid,
  output logic [addre_width-1:0]    rf_addr,
  output logic                      rf_wr_en,
  output logic [data_width-1:0]     rf_wr_data,
  output logic                      rf_rd_en,
  input  logic [data_width-1:0]     rf_rd_data,
  input  logic                      rf_rd_valid,
  output logic                      alu_en,
  output logic [alu_func_width-1:0] alu_func,
  input  logic [2*data_width-1:0]   alu_out,
  input  logic                      alu_out_valid,
  output logic                      gate_en,
  output logic [data_width-1:0]     fifo_wr_data,
  output logic                      fifo_wr_inc,
  input  logic                      fifo_full,
  output logic                      cmd_error
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_ADDR  = 4'd1;
  localparam logic [3:0] S_WR_DATA  = 4'd2;
  localparam logic [3:0] S_RD_ADDR  = 4'd3;
  localparam logic [3:0] S_RD_WAIT  = 4'd4;
  localparam logic [3:0] S_ALU_A    = 4'd5;
  localparam logic [3:0] S_ALU_B    = 4'd6;
  localparam logic [3:0] S_ALU_FUNC = 4'd7;
  localparam logic [3:0] S_ALU_WAIT = 4'd8;
  localparam logic [3:0] S_TX_LS    = 4'd9;
  localparam logic [3:0] S_TX_MS    = 4'd10;

  localparam logic [data_width-1:0] CMD_WR    = data_width'(8'hAA);
  localparam logic [data_width-1:0] CMD_RD    = data_width'(8'hBB);
  localparam logic [data_width-1:0] CMD_ALU   = data_width'(8'hCC);
  localparam logic [data_width-1:0] CMD_ALU_N = data_width'(8'hDD);

  logic [3:0]                state_q, state_d;
  logic [addre_width-1:0]    rf_addr_q, rf_addr_d;
  logic [data_width-1:0]     rf_wr_data_q, rf_wr_data_d;
  logic [alu_func_width-1:0] alu_func_q, alu_func_d;
  logic [2*data_width-1:0]   result_q, result_d;
  logic                      rf_wr_en_q, rf_wr_en_d;
  logic                      rf_rd_en_q, rf_rd_en_d;
  logic                      alu_en_q, alu_en_d;
  logic                      cmd_error_q, cmd_error_d;
  logic                      in_tx;

  always_comb begin
    state_d      = state_q;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_func_d   = alu_func_q;
    result_d     = result_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    alu_en_d     = 1'b0;
    cmd_error_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_d_valid) begin
          case (rx_p_data)
            CMD_WR:    state_d = S_WR_ADDR;
            CMD_RD:    state_d = S_RD_ADDR;
            CMD_ALU:   state_d = S_ALU_A;
            CMD_ALU_N: state_d = S_ALU_FUNC;
            default:   cmd_error_d = 1'b1;
          endcase
        end
      end
      S_WR_ADDR: begin
        if (rx_d_valid) begin
          rf_addr_d = rx_p_data[addre_width-1:0];
          state_d   = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (rx_d_valid) begin
          rf_wr_data_d = rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (rx_d_valid) begin
          rf_addr_d  = rx_p_data[addre_width-1:0];
          rf_rd_en_d = 1'b1;
          state_d    = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        // The read byte sits in the upper half so TX_MS pushes it as a single byte.
        if (rf_rd_valid) begin
          result_d = {rf_rd_data, {data_width{1'b0}}};
          state_d  = S_TX_MS;
        end
      end
      S_ALU_A: begin
        if (rx_d_valid) begin
          rf_addr_d    = '0;
          rf_wr_data_d = rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = S_ALU_B;
        end
      end
      S_ALU_B: begin
        if (rx_d_valid) begin
          rf_addr_d    = addre_width'(1);
          rf_wr_data_d = rx_p_data;
          rf_wr_en_d   = 1'b1;
          state_d      = S_ALU_FUNC;
        end
      end
      S_ALU_FUNC: begin
        if (rx_d_valid) begin
          alu_func_d = rx_p_data[alu_func_width-1:0];
          alu_en_d   = 1'b1;
          state_d    = S_ALU_WAIT;
        end
      end
      S_ALU_WAIT: begin
        if (alu_out_valid) begin
          result_d = alu_out;
          state_d  = S_TX_LS;
        end
      end
      S_TX_LS: if (!fifo_full) state_d = S_TX_MS;
      S_TX_MS: if (!fifo_full) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_func_q   <= '0;
      result_q     <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      alu_en_q     <= 1'b0;
      cmd_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_func_q   <= alu_func_d;
      result_q     <= result_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      alu_en_q     <= alu_en_d;
      cmd_error_q  <= cmd_error_d;
    end
  end

  assign in_tx        = (state_q == S_TX_LS) || (state_q == S_TX_MS);
  assign fifo_wr_inc  = in_tx && !fifo_full;
  // Data is a pure function of state and the result register, so it holds while the FIFO is full.
  assign fifo_wr_data = (state_q == S_TX_LS) ? result_q[data_width-1:0]
                                             : result_q[2*data_width-1:data_width];
  assign gate_en      = (state_q == S_ALU_FUNC) || (state_q == S_ALU_WAIT);
  assign rf_addr      = rf_addr_q;
  assign rf_wr_data   = rf_wr_data_q;
  assign rf_wr_en     = rf_wr_en_q;
  assign rf_rd_en     = rf_rd_en_q;
  assign alu_en       = alu_en_q;
  assign alu_func     = alu_func_q;
  assign cmd_error    = cmd_error_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Testbench for sys_cmd_ctrl: directed command frames against hand-computed results.
// Stimulus changes on the falling edge; outputs are checked 1 ns after it.
// A register-file model answers reads two cycles after rf_rd_en; ALU results are driven directly.
module tb_sys_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_p_data = '0;
  logic        rx_d_valid = 1'b0;
  logic [3:0]  rf_addr;
  logic        rf_wr_en;
  logic [7:0]  rf_wr_data;
  logic        rf_rd_en;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_valid;
  logic        alu_en;
  logic [3:0]  alu_func;
  logic [15:0] alu_out = '0;
  logic        alu_out_valid = 1'b0;
  logic        gate_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_wr_inc;
  logic        fifo_full = 1'b0;
  logic        cmd_error;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, alu_cnt = 0, err_cnt = 0;
  logic [7:0] pushes[$];

  sys_cmd_ctrl #(.data_width(8), .addre_width(4), .alu_func_width(4)) dut (
    .clk(clk), .rst(rst),
    .rx_p_data(rx_p_data), .rx_d_valid(rx_d_valid),
    .rf_addr(rf_addr), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
    .rf_rd_en(rf_rd_en), .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid),
    .alu_en(alu_en), .alu_func(alu_func), .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .gate_en(gate_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_inc(fifo_wr_inc),
    .fifo_full(fifo_full), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  // Register-file model: write on strobe, read data returned with valid two cycles after rf_rd_en.
  logic [7:0] mem [16];
  logic [1:0] rd_pipe;
  logic [7:0] rd_dat;
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rd_pipe = '0;
    rd_dat  = '0;
  end
  always @(posedge clk) begin
    if (rf_wr_en) mem[rf_addr] <= rf_wr_data;
    if (rf_rd_en) rd_dat <= mem[rf_addr];
    rd_pipe <= {rd_pipe[0], rf_rd_en};
  end
  assign rf_rd_valid = rd_pipe[1];
  assign rf_rd_data  = rd_dat;

  // Activity monitor: counts strobes and logs every FIFO push (each spans exactly one falling edge).
  always begin
    @(negedge clk);
    #2;
    if (rf_wr_en)    wr_cnt++;
    if (rf_rd_en)    rd_cnt++;
    if (alu_en)      alu_cnt++;
    if (cmd_error)   err_cnt++;
    if (fifo_wr_inc) pushes.push_back(fifo_wr_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drives one byte for one cycle; returns in the cycle after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_p_data  = b;
    rx_d_valid = 1'b1;
    @(negedge clk);
    rx_d_valid = 1'b0;
    #1;
  endtask

  task automatic pulse_alu(input logic [15:0] r);
    @(negedge clk);
    alu_out       = r;
    alu_out_valid = 1'b1;
    @(negedge clk);
    alu_out_valid = 1'b0;
    #1;
  endtask

  function automatic logic [7:0] push_at(input int idx);
    if (idx < pushes.size()) return pushes[idx];
    return 8'hxx;
  endfunction

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++; if ({rf_wr_en, rf_rd_en, alu_en, cmd_error} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {rf_wr_en, rf_rd_en, alu_en, cmd_error}); end
    checks++; if ({fifo_wr_inc, gate_en} !== 2'b0) begin errors++; $display("FAIL reset_inc_gate: got %b want 00", {fifo_wr_inc, gate_en}); end
    checks++; if ({rf_addr, rf_wr_data, alu_func, fifo_wr_data} !== 24'h0) begin errors++; $display("FAIL reset_buses: got %h want 000000", {rf_addr, rf_wr_data, alu_func, fifo_wr_data}); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int w0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h0A);
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL write_no_early_strobe: got %b want 0", rf_wr_en); end
    send_byte(8'hAA);
    checks++; if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'd10, 8'hAA}) begin errors++; $display("FAIL write_strobe: got en=%b addr=%0d data=%h want en=1 addr=10 data=aa", rf_wr_en, rf_addr, rf_wr_data); end
    tick();
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL write_one_cycle: got %b want 0", rf_wr_en); end
    tick();
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL write_count: got %0d want 1", wr_cnt - w0); end
  endtask

  task automatic test_read();
    int n0 = pushes.size();
    send_byte(8'hBB);
    send_byte(8'h0A);
    checks++; if ({rf_rd_en, rf_addr} !== {1'b1, 4'd10}) begin errors++; $display("FAIL read_strobe: got en=%b addr=%0d want en=1 addr=10", rf_rd_en, rf_addr); end
    repeat (8) tick();
    checks++; if (pushes.size() - n0 !== 1) begin errors++; $display("FAIL read_push_count: got %0d want 1", pushes.size() - n0); end
    checks++; if (push_at(n0) !== 8'hAA) begin errors++; $display("FAIL read_push_data: got %h want aa", push_at(n0)); end
  endtask

  task automatic test_alu_operands();
    int n0 = pushes.size();
    send_byte(8'hCC);
    send_byte(8'd200);
    checks++; if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'd0, 8'hC8}) begin errors++; $display("FAIL alu_op_a: got en=%b addr=%0d data=%h want en=1 addr=0 data=c8", rf_wr_en, rf_addr, rf_wr_data); end
    send_byte(8'd250);
    checks++; if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'd1, 8'hFA}) begin errors++; $display("FAIL alu_op_b: got en=%b addr=%0d data=%h want en=1 addr=1 data=fa", rf_wr_en, rf_addr, rf_wr_data); end
    send_byte(8'h02);
    checks++; if ({alu_en, alu_func, gate_en} !== {1'b1, 4'd2, 1'b1}) begin errors++; $display("FAIL alu_start: got en=%b func=%0d gate=%b want en=1 func=2 gate=1", alu_en, alu_func, gate_en); end
    pulse_alu(16'hC350);
    checks++; if ({fifo_wr_inc, fifo_wr_data} !== {1'b1, 8'h50}) begin errors++; $display("FAIL alu_first_push: got inc=%b data=%h want inc=1 data=50", fifo_wr_inc, fifo_wr_data); end
    repeat (4) tick();
    checks++; if (gate_en !== 1'b0) begin errors++; $display("FAIL alu_gate_off: got %b want 0", gate_en); end
    checks++; if ({push_at(n0), push_at(n0 + 1)} !== 16'h50C3 || pushes.size() - n0 != 2) begin errors++; $display("FAIL alu_pushes: got %h %h (n=%0d) want 50 c3 (n=2)", push_at(n0), push_at(n0 + 1), pushes.size() - n0); end
  endtask

  task automatic test_alu_no_operands();
    int n0 = pushes.size();
    int w0 = wr_cnt;
    send_byte(8'hDD);
    send_byte(8'h00);
    checks++; if ({alu_en, alu_func} !== {1'b1, 4'd0}) begin errors++; $display("FAIL alun_start0: got en=%b func=%0d want en=1 func=0", alu_en, alu_func); end
    pulse_alu(16'h01C2);
    repeat (4) tick();
    send_byte(8'hDD);
    send_byte(8'h03);
    checks++; if ({alu_en, alu_func} !== {1'b1, 4'd3}) begin errors++; $display("FAIL alun_start3: got en=%b func=%0d want en=1 func=3", alu_en, alu_func); end
    pulse_alu(16'h0028);
    repeat (4) tick();
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL alun_no_writes: got %0d want 0", wr_cnt - w0); end
    checks++; if ({push_at(n0), push_at(n0 + 1), push_at(n0 + 2), push_at(n0 + 3)} !== 32'hC201_2800 || pushes.size() - n0 != 4) begin errors++; $display("FAIL alun_pushes: got %h %h %h %h (n=%0d) want c2 01 28 00 (n=4)", push_at(n0), push_at(n0 + 1), push_at(n0 + 2), push_at(n0 + 3), pushes.size() - n0); end
  endtask

  task automatic test_backpressure_drop();
    int n0 = pushes.size();
    int w0 = wr_cnt;
    int r0 = rd_cnt;
    int e0 = err_cnt;
    send_byte(8'hDD);
    send_byte(8'h01);
    // Byte during ALU_WAIT must be dropped.
    send_byte(8'hBB);
    send_byte(8'h55);
    fifo_full = 1'b1;
    pulse_alu(16'h1234);
    for (int i = 0; i < 5; i++) begin
      checks++; if ({fifo_wr_inc, fifo_wr_data} !== {1'b0, 8'h34}) begin errors++; $display("FAIL bp_hold_%0d: got inc=%b data=%h want inc=0 data=34", i, fifo_wr_inc, fifo_wr_data); end
      tick();
    end
    fifo_full = 1'b0;
    #1;
    checks++; if ({fifo_wr_inc, fifo_wr_data} !== {1'b1, 8'h34}) begin errors++; $display("FAIL bp_release_ls: got inc=%b data=%h want inc=1 data=34", fifo_wr_inc, fifo_wr_data); end
    tick();
    checks++; if ({fifo_wr_inc, fifo_wr_data} !== {1'b1, 8'h12}) begin errors++; $display("FAIL bp_ms: got inc=%b data=%h want inc=1 data=12", fifo_wr_inc, fifo_wr_data); end
    tick();
    checks++; if (fifo_wr_inc !== 1'b0) begin errors++; $display("FAIL bp_done: got %b want 0", fifo_wr_inc); end
    tick();
    checks++; if (pushes.size() - n0 !== 2) begin errors++; $display("FAIL bp_push_count: got %0d want 2", pushes.size() - n0); end
    checks++; if ((wr_cnt - w0) + (rd_cnt - r0) + (err_cnt - e0) !== 0) begin errors++; $display("FAIL drop_no_strobes: got %0d want 0", (wr_cnt - w0) + (rd_cnt - r0) + (err_cnt - e0)); end
  endtask

  task automatic test_error();
    int w0 = wr_cnt, r0 = rd_cnt, a0 = alu_cnt, e0 = err_cnt;
    send_byte(8'h55);
    checks++; if ({cmd_error, rf_wr_en, rf_rd_en, alu_en} !== 4'b1000) begin errors++; $display("FAIL err_pulse: got %b want 1000", {cmd_error, rf_wr_en, rf_rd_en, alu_en}); end
    tick();
    checks++; if (cmd_error !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b want 0", cmd_error); end
    tick();
    checks++; if ({err_cnt - e0, wr_cnt - w0, rd_cnt - r0, alu_cnt - a0} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin errors++; $display("FAIL err_counts: got err=%0d wr=%0d rd=%0d alu=%0d want 1 0 0 0", err_cnt - e0, wr_cnt - w0, rd_cnt - r0, alu_cnt - a0); end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_cnt;
    send_byte(8'hAA);
    send_byte(8'h05);
    checks++; if (rf_addr !== 4'd5) begin errors++; $display("FAIL mid_addr_latched: got %0d want 5", rf_addr); end
    rst = 1'b1;
    #1;
    checks++; if ({rf_addr, rf_wr_data, alu_func, fifo_wr_data, rf_wr_en, cmd_error} !== 26'h0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 0", {rf_addr, rf_wr_data, alu_func, fifo_wr_data, rf_wr_en, cmd_error}); end
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h12);
    checks++; if ({cmd_error, rf_wr_en} !== 2'b10) begin errors++; $display("FAIL mid_after_reset: got err=%b wr=%b want err=1 wr=0", cmd_error, rf_wr_en); end
    tick();
    checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL mid_no_write: got %0d want 0", wr_cnt - w0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [5];
    int n0 = pushes.size();
    seq[0] = 8'hAA; seq[1] = 8'h03; seq[2] = 8'h77; seq[3] = 8'hBB; seq[4] = 8'h03;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx_p_data  = seq[i];
      rx_d_valid = 1'b1;
      #1;
      if (i == 3) begin
        checks++; if ({rf_wr_en, rf_addr, rf_wr_data} !== {1'b1, 4'd3, 8'h77}) begin errors++; $display("FAIL b2b_write: got en=%b addr=%0d data=%h want en=1 addr=3 data=77", rf_wr_en, rf_addr, rf_wr_data); end
      end
    end
    @(negedge clk);
    rx_d_valid = 1'b0;
    #1;
    checks++; if ({rf_rd_en, rf_addr} !== {1'b1, 4'd3}) begin errors++; $display("FAIL b2b_read: got en=%b addr=%0d want en=1 addr=3", rf_rd_en, rf_addr); end
    repeat (8) tick();
    checks++; if (push_at(n0) !== 8'h77 || pushes.size() - n0 != 1) begin errors++; $display("FAIL b2b_push: got %h (n=%0d) want 77 (n=1)", push_at(n0), pushes.size() - n0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_alu_operands();
    test_alu_no_operands();
    test_backpressure_drop();
    test_error();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
